// File: rtl/ula_multiciclo.sv
// ---------------------------------------------------------------------------
// ula_multiciclo
//
// Multi-cycle ALU for the execute stage of the multi-cycle datapath. It keeps
// the legacy 4-bit ALU control encoding and the zero flag, widened to LARGURA
// bits. It adds XOR, shifts and signed SLT, plus iterative unsigned
// multiply/divide/remainder behind a start/busy/done handshake.
//
// Single-cycle operations write saida at the clock edge that samples inicio.
// MUL/DIVU/REMU take LARGURA cycles in CALC, one bit per cycle.
//
// Ports:
//   clock          in   rising-edge system clock
//   reset          in   synchronous, active-high
//   inicio         in   start; only sampled while ocupado = 0
//   controladorULA in   4-bit operation select, sampled with inicio
//   dados1         in   operand A (LARGURA bits), sampled with inicio
//   dados2         in   operand B (LARGURA bits), sampled with inicio
//   saida          out  registered result, held until the next completion
//   zero           out  high when the registered saida is all zeros
//   ocupado        out  high while an iterative operation is in progress
//   pronto         out  one-cycle pulse in the first cycle a new saida is valid
// ---------------------------------------------------------------------------
module ula_multiciclo #(
    parameter int LARGURA = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inicio,
    input  logic [3:0]         controladorULA,
    input  logic [LARGURA-1:0] dados1,
    input  logic [LARGURA-1:0] dados2,
    output logic [LARGURA-1:0] saida,
    output logic               zero,
    output logic               ocupado,
    output logic               pronto
);

    // The shift-amount width follows from LARGURA and is not meant to be set
    // by the instantiating module.
    localparam int SHAMT = $clog2(LARGURA);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;
    localparam logic [3:0] OP_SLT  = 4'b1011;

    typedef enum logic {
        OCIOSO,
        CALC
    } estado_t;

    estado_t            estado_q,  estado_d;
    logic [3:0]         opcode_q,  opcode_d;
    logic [LARGURA-1:0] regA_q,    regA_d;
    logic [LARGURA-1:0] regB_q,    regB_d;
    logic [LARGURA-1:0] acc_q,     acc_d;
    logic [LARGURA-1:0] saida_q,   saida_d;
    logic [SHAMT-1:0]   cnt_q,     cnt_d;
    logic               pronto_q,  pronto_d;

    logic [LARGURA-1:0] resultadoSimples;
    logic [SHAMT-1:0]   shamt;
    logic               ehIterativa;
    logic [LARGURA-1:0] somaMul;
    logic [LARGURA:0]   restoDesl;
    logic               cabe;

    // Result of the single-cycle operations, computed straight from the
    // inputs so it can be written at the same edge that accepts inicio.
    // Unknown codes give zero.
    always_comb begin
        shamt            = dados2[SHAMT-1:0];
        resultadoSimples = '0;
        case (controladorULA)
            OP_AND:  resultadoSimples = dados1 & dados2;
            OP_OR:   resultadoSimples = dados1 | dados2;
            OP_ADD:  resultadoSimples = dados1 + dados2;
            OP_SUB:  resultadoSimples = dados1 - dados2;
            OP_XOR:  resultadoSimples = dados1 ^ dados2;
            OP_SLL:  resultadoSimples = dados1 << shamt;
            OP_SRL:  resultadoSimples = dados1 >> shamt;
            OP_SLTU: resultadoSimples = {{(LARGURA-1){1'b0}}, (dados1 < dados2)};
            OP_SLT:  resultadoSimples = {{(LARGURA-1){1'b0}},
                                         ($signed(dados1) < $signed(dados2))};
            default: resultadoSimples = '0;
        endcase
    end

    // Opcodes that go through the iterative datapath instead of finishing
    // in one cycle.
    always_comb begin
        ehIterativa = (controladorULA == OP_MUL) ||
                      (controladorULA == OP_DIVU) ||
                      (controladorULA == OP_REMU);
    end

    // One iteration of each algorithm.
    // MUL: shift-add; regA holds the multiplicand moving left, regB the
    // multiplier moving right, acc the low LARGURA bits of the partial
    // product (upper bits are never needed).
    // DIVU/REMU: restoring division; regA holds the dividend shifting out at
    // the top while quotient bits shift in at the bottom, acc is the partial
    // remainder. The shifted remainder needs one extra bit before the compare.
    // With a zero divisor every step "fits", which yields an all-ones
    // quotient and leaves the dividend as the remainder.
    always_comb begin
        somaMul   = acc_q + (regB_q[0] ? regA_q : '0);
        restoDesl = {acc_q, regA_q[LARGURA-1]};
        cabe      = (restoDesl >= {1'b0, regB_q});
    end

    // Next-state logic for the FSM and datapath registers. Everything holds
    // by default; pronto is a pulse so it defaults to zero.
    always_comb begin
        estado_d = estado_q;
        opcode_d = opcode_q;
        regA_d   = regA_q;
        regB_d   = regB_q;
        acc_d    = acc_q;
        saida_d  = saida_q;
        cnt_d    = cnt_q;
        pronto_d = 1'b0;

        case (estado_q)
            OCIOSO: begin
                if (inicio) begin
                    if (ehIterativa) begin
                        estado_d = CALC;
                        opcode_d = controladorULA;
                        regA_d   = dados1;
                        regB_d   = dados2;
                        acc_d    = '0;
                        cnt_d    = SHAMT'(LARGURA - 1);
                    end else begin
                        saida_d  = resultadoSimples;
                        pronto_d = 1'b1;
                    end
                end
            end

            CALC: begin
                cnt_d = cnt_q - {{(SHAMT-1){1'b0}}, 1'b1};
                if (opcode_q == OP_MUL) begin
                    acc_d  = somaMul;
                    regA_d = regA_q << 1;
                    regB_d = regB_q >> 1;
                end else begin
                    regA_d = {regA_q[LARGURA-2:0], cabe};
                    acc_d  = cabe ? (restoDesl[LARGURA-1:0] - regB_q)
                                  : restoDesl[LARGURA-1:0];
                end

                // The counter started at LARGURA-1, so reaching zero here
                // means this edge performs the last iteration.
                if (cnt_q == '0) begin
                    estado_d = OCIOSO;
                    pronto_d = 1'b1;
                    if (opcode_q == OP_DIVU) begin
                        saida_d = regA_d;
                    end else begin
                        saida_d = acc_d;
                    end
                end
            end

            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // State and datapath registers. Reset aborts any operation in flight
    // without producing pronto.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= OCIOSO;
            opcode_q <= '0;
            regA_q   <= '0;
            regB_q   <= '0;
            acc_q    <= '0;
            saida_q  <= '0;
            cnt_q    <= '0;
            pronto_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            opcode_q <= opcode_d;
            regA_q   <= regA_d;
            regB_q   <= regB_d;
            acc_q    <= acc_d;
            saida_q  <= saida_d;
            cnt_q    <= cnt_d;
            pronto_q <= pronto_d;
        end
    end

    // Outputs come straight from registers; zero is decoded from the
    // registered result so it only moves when saida does.
    always_comb begin
        saida   = saida_q;
        zero    = (saida_q == '0);
        ocupado = (estado_q == CALC);
        pronto  = pronto_q;
    end

endmodule

// File: tb/tb_ula_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_ula_multiciclo
//
// Directed testbench for ula_multiciclo. Drives a 32-bit instance through the
// single-cycle operations, MUL/DIVU/REMU timing, back-to-back issue, unknown
// opcodes and reset abort, then runs a short set of cases on an 8-bit
// instance. Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_ula_multiciclo;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;
    localparam logic [3:0] OP_SLT  = 4'b1011;
    localparam logic [3:0] OP_UNK  = 4'b1111;

    logic        clock;
    logic        reset;
    logic        inicio;
    logic [3:0]  controladorULA;
    logic [31:0] dados1;
    logic [31:0] dados2;
    logic [31:0] saida;
    logic        zero;
    logic        ocupado;
    logic        pronto;

    logic        inicio8;
    logic [3:0]  controladorULA8;
    logic [7:0]  dados1_8;
    logic [7:0]  dados2_8;
    logic [7:0]  saida8;
    logic        zero8;
    logic        ocupado8;
    logic        pronto8;

    int errors;
    int checks;

    ula_multiciclo #(.LARGURA(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .inicio         (inicio),
        .controladorULA (controladorULA),
        .dados1         (dados1),
        .dados2         (dados2),
        .saida          (saida),
        .zero           (zero),
        .ocupado        (ocupado),
        .pronto         (pronto)
    );

    ula_multiciclo #(.LARGURA(8)) dut8 (
        .clock          (clock),
        .reset          (reset),
        .inicio         (inicio8),
        .controladorULA (controladorULA8),
        .dados1         (dados1_8),
        .dados2         (dados2_8),
        .saida          (saida8),
        .zero           (zero8),
        .ocupado        (ocupado8),
        .pronto         (pronto8)
    );

    // 10-unit clock period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case something hangs far beyond the expected run length.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, expected finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one request on the 32-bit instance for exactly one edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        inicio         = 1'b1;
        controladorULA = op;
        dados1         = a;
        dados2         = b;
        tick();
        inicio         = 1'b0;
    endtask

    task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        inicio8         = 1'b1;
        controladorULA8 = op;
        dados1_8        = a;
        dados2_8        = b;
        tick();
        inicio8         = 1'b0;
    endtask

    // Wait (bounded) for pronto on the 32-bit instance, counting busy cycles.
    task automatic waitDone(output int ocup);
        ocup = 0;
        for (int i = 0; i < 100; i++) begin
            if (pronto) break;
            if (ocupado) ocup++;
            tick();
        end
    endtask

    task automatic waitDone8(output int ocup);
        ocup = 0;
        for (int i = 0; i < 40; i++) begin
            if (pronto8) break;
            if (ocupado8) ocup++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (saida !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_saida: got %h expected %h", saida, 32'h0);
        end
        checks++;
        if ({zero, ocupado, pronto} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL reset_flags: got zero/ocupado/pronto=%b expected %b",
                     {zero, ocupado, pronto}, 3'b100);
        end
        checks++;
        if (saida8 !== 8'h0 || zero8 !== 1'b1 || ocupado8 !== 1'b0 || pronto8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_8bit: got saida=%h z/o/p=%b expected 00 100",
                     saida8, {zero8, ocupado8, pronto8});
        end
    endtask

    task automatic test_add_sub();
        issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        checks++;
        if (saida !== 32'h8000_0000 || pronto !== 1'b1 || zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_overflow: got saida=%h pronto=%b zero=%b expected 80000000 1 0",
                     saida, pronto, zero);
        end
        tick();
        checks++;
        if (pronto !== 1'b0 || saida !== 32'h8000_0000) begin
            errors++;
            $display("[TB] FAIL add_pulse: got pronto=%b saida=%h expected 0 80000000", pronto, saida);
        end
        issue(OP_SUB, 32'd5, 32'd5);
        checks++;
        if (saida !== 32'h0 || zero !== 1'b1 || pronto !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sub_zero: got saida=%h zero=%b pronto=%b expected 0 1 1",
                     saida, zero, pronto);
        end
    endtask

    task automatic test_single_ops();
        logic [3:0]  ops [8];
        logic [31:0] as  [8];
        logic [31:0] bs  [8];
        logic [31:0] exp [8];
        ops[0] = OP_SLTU; as[0] = 32'hFFFF_FFFF; bs[0] = 32'h1;          exp[0] = 32'h0;
        ops[1] = OP_SLT;  as[1] = 32'hFFFF_FFFF; bs[1] = 32'h1;          exp[1] = 32'h1;
        ops[2] = OP_SLL;  as[2] = 32'h1;         bs[2] = 32'h23;         exp[2] = 32'h8;
        ops[3] = OP_SRL;  as[3] = 32'h8000_0000; bs[3] = 32'd31;         exp[3] = 32'h1;
        ops[4] = OP_AND;  as[4] = 32'hF0F0_F0F0; bs[4] = 32'hFF00_FF00;  exp[4] = 32'hF000_F000;
        ops[5] = OP_OR;   as[5] = 32'hF0F0_F0F0; bs[5] = 32'hFF00_FF00;  exp[5] = 32'hFFF0_FFF0;
        ops[6] = OP_XOR;  as[6] = 32'hF0F0_F0F0; bs[6] = 32'hFF00_FF00;  exp[6] = 32'h0FF0_0FF0;
        ops[7] = OP_SUB;  as[7] = 32'h0;         bs[7] = 32'h1;          exp[7] = 32'hFFFF_FFFF;
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], as[i], bs[i]);
            checks++;
            if (saida !== exp[i] || pronto !== 1'b1 || ocupado !== 1'b0) begin
                errors++;
                $display("[TB] FAIL single_op%0d (op %b): got saida=%h pronto=%b ocupado=%b expected %h 1 0",
                         i, ops[i], saida, pronto, ocupado, exp[i]);
            end
        end
    endtask

    task automatic test_mul();
        int ocup;
        issue(OP_ADD, 32'h11, 32'h22);
        issue(OP_MUL, 32'h0001_0000, 32'h0001_0003);
        ocup = 0;
        for (int i = 0; i < 100; i++) begin
            if (pronto) break;
            if (ocupado) ocup++;
            if (i == 5) begin
                inicio         = 1'b1;
                controladorULA = OP_ADD;
                dados1         = 32'h1;
                dados2         = 32'h1;
            end else begin
                inicio         = 1'b0;
                dados1         = 32'hDEAD_BEEF;
                dados2         = 32'h1234_5678;
            end
            if (i == 10) begin
                checks++;
                if (saida !== 32'h33 || pronto !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL mul_hold: got saida=%h pronto=%b expected 00000033 0", saida, pronto);
                end
            end
            tick();
        end
        inicio = 1'b0;
        checks++;
        if (ocup !== 32) begin
            errors++;
            $display("[TB] FAIL mul_busy_cycles: got %0d expected %0d", ocup, 32);
        end
        checks++;
        if (saida !== 32'h0003_0000 || pronto !== 1'b1 || ocupado !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mul_result: got saida=%h pronto=%b ocupado=%b expected 00030000 1 0",
                     saida, pronto, ocupado);
        end
        tick();
        checks++;
        if (pronto !== 1'b0 || saida !== 32'h0003_0000) begin
            errors++;
            $display("[TB] FAIL mul_after: got pronto=%b saida=%h expected 0 00030000", pronto, saida);
        end
    endtask

    task automatic test_divide();
        int ocup;
        logic [3:0]  ops [4];
        logic [31:0] as  [4];
        logic [31:0] bs  [4];
        logic [31:0] exp [4];
        ops[0] = OP_DIVU; as[0] = 32'd100; bs[0] = 32'd7; exp[0] = 32'd14;
        ops[1] = OP_REMU; as[1] = 32'd100; bs[1] = 32'd7; exp[1] = 32'd2;
        ops[2] = OP_DIVU; as[2] = 32'd9;   bs[2] = 32'd0; exp[2] = 32'hFFFF_FFFF;
        ops[3] = OP_REMU; as[3] = 32'd9;   bs[3] = 32'd0; exp[3] = 32'd9;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i]);
            waitDone(ocup);
            checks++;
            if (saida !== exp[i] || pronto !== 1'b1 || ocup !== 32) begin
                errors++;
                $display("[TB] FAIL divide%0d (op %b %0d/%0d): got saida=%h pronto=%b busy=%0d expected %h 1 32",
                         i, ops[i], as[i], bs[i], saida, pronto, ocup, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int ocup;
        issue(OP_DIVU, 32'd100, 32'd7);
        waitDone(ocup);
        // Issue the next request in the pronto cycle of the previous one.
        issue(OP_MUL, 32'd3, 32'd5);
        checks++;
        if (ocupado !== 1'b1 || pronto !== 1'b0 || saida !== 32'd14) begin
            errors++;
            $display("[TB] FAIL b2b_accept: got ocupado=%b pronto=%b saida=%h expected 1 0 0000000e",
                     ocupado, pronto, saida);
        end
        waitDone(ocup);
        checks++;
        if (ocup !== 32 || saida !== 32'd15 || pronto !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_mul: got busy=%0d saida=%h pronto=%b expected 32 0000000f 1",
                     ocup, saida, pronto);
        end
        // Unknown opcode, also issued straight in the pronto cycle.
        issue(OP_UNK, 32'd5, 32'd5);
        checks++;
        if (saida !== 32'h0 || zero !== 1'b1 || pronto !== 1'b1 || ocupado !== 1'b0) begin
            errors++;
            $display("[TB] FAIL unknown_op: got saida=%h zero=%b pronto=%b ocupado=%b expected 0 1 1 0",
                     saida, zero, pronto, ocupado);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int prontoSeen;
        issue(OP_ADD, 32'd1, 32'd2);
        checks++;
        if (saida !== 32'd3) begin
            errors++;
            $display("[TB] FAIL abort_setup: got saida=%h expected %h", saida, 32'd3);
        end
        issue(OP_MUL, 32'd3, 32'd5);
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (ocupado !== 1'b0 || saida !== 32'h0 || pronto !== 1'b0 || zero !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_state: got ocupado=%b saida=%h pronto=%b zero=%b expected 0 0 0 1",
                     ocupado, saida, pronto, zero);
        end
        prontoSeen = 0;
        for (int i = 0; i < 40; i++) begin
            if (pronto) prontoSeen++;
            tick();
        end
        checks++;
        if (prontoSeen !== 0 || saida !== 32'h0) begin
            errors++;
            $display("[TB] FAIL abort_no_pronto: got pronto count=%0d saida=%h expected 0 0",
                     prontoSeen, saida);
        end
    endtask

    task automatic test_largura8();
        int ocup;
        logic [3:0] ops  [9];
        logic [7:0] as   [9];
        logic [7:0] bs   [9];
        logic [7:0] exp  [9];
        int         busy [9];
        ops[0] = OP_MUL;  as[0] = 8'd15;  bs[0] = 8'd17; exp[0] = 8'hFF; busy[0] = 8;
        ops[1] = OP_DIVU; as[1] = 8'd200; bs[1] = 8'd7;  exp[1] = 8'd28; busy[1] = 8;
        ops[2] = OP_REMU; as[2] = 8'd200; bs[2] = 8'd7;  exp[2] = 8'd4;  busy[2] = 8;
        ops[3] = OP_DIVU; as[3] = 8'd9;   bs[3] = 8'd0;  exp[3] = 8'hFF; busy[3] = 8;
        ops[4] = OP_REMU; as[4] = 8'd9;   bs[4] = 8'd0;  exp[4] = 8'd9;  busy[4] = 8;
        ops[5] = OP_ADD;  as[5] = 8'h7F;  bs[5] = 8'h01; exp[5] = 8'h80; busy[5] = 0;
        ops[6] = OP_SLT;  as[6] = 8'hFF;  bs[6] = 8'h01; exp[6] = 8'h01; busy[6] = 0;
        ops[7] = OP_SLTU; as[7] = 8'hFF;  bs[7] = 8'h01; exp[7] = 8'h00; busy[7] = 0;
        ops[8] = OP_SLL;  as[8] = 8'h01;  bs[8] = 8'h0B; exp[8] = 8'h08; busy[8] = 0;
        for (int i = 0; i < 9; i++) begin
            issue8(ops[i], as[i], bs[i]);
            waitDone8(ocup);
            checks++;
            if (saida8 !== exp[i] || pronto8 !== 1'b1 || ocup !== busy[i] ||
                zero8 !== (exp[i] == 8'h0)) begin
                errors++;
                $display("[TB] FAIL w8_case%0d (op %b): got saida=%h pronto=%b busy=%0d zero=%b expected %h 1 %0d %b",
                         i, ops[i], saida8, pronto8, ocup, zero8, exp[i], busy[i], (exp[i] == 8'h0));
            end
            tick();
        end
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        reset           = 1'b1;
        inicio          = 1'b0;
        controladorULA  = 4'b0000;
        dados1          = '0;
        dados2          = '0;
        inicio8         = 1'b0;
        controladorULA8 = 4'b0000;
        dados1_8        = '0;
        dados2_8        = '0;

        test_reset();
        test_add_sub();
        test_single_ops();
        test_mul();
        test_divide();
        test_back_to_back();
        test_reset_abort();
        test_largura8();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ula_multiciclo.md
Name: ula_multiciclo

Overview:
Parametrised multi-cycle successor to the processor's combinational ALU. Keeps the existing 4-bit ALU control encoding and `zero` flag, generalised to LARGURA bits. Adds XOR, shifts, signed SLT, and iterative unsigned multiply/divide/remainder behind a start/busy/done handshake. Sits in the execute stage of the multi-cycle datapath; the control FSM stalls while `ocupado` is high.

Parameters:
LARGURA, 32, operand/result width; power of 2, >= 8
SHAMT, $clog2(LARGURA), shift-amount field width (derived, not overridable)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
inicio  input  1  start; sampled only when ocupado=0
controladorULA  input  4  operation select, sampled with inicio
dados1  input  LARGURA  operand A, sampled with inicio
dados2  input  LARGURA  operand B, sampled with inicio
saida  output  LARGURA  registered result; holds until next completion
zero  output  1  (saida == 0), derived from registered saida
ocupado  output  1  high while an iterative op is in progress
pronto  output  1  one-cycle pulse in the first cycle a new saida is valid

Behaviour:
- Single clock `clock`; reset synchronous, active-high. Reset: saida=0, zero=1, ocupado=0, pronto=0, FSM=OCIOSO, internal accumulators cleared.
- Opcodes, with A/B as latched operands:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (all mod 2^LARGURA).
  - 0011 XOR.
  - 0100 SLL A<<B[SHAMT-1:0]; 0101 SRL (logical) by the same field.
  - 0111 SLTU: 1 if A<B unsigned, else 0. Same as the legacy SLT.
  - 1011 SLT: signed compare.
  - 1000 MUL: low LARGURA bits of A*B, unsigned.
  - 1001 DIVU: quotient. 1010 REMU: remainder.
  - Any other code: saida=0.
- FSM states:
  - OCIOSO to (single-cycle op) OCIOSO. Result is written at the edge that samples inicio. pronto=1 the next cycle. Latency 1.
  - OCIOSO to CALC for 1000/1001/1010. ocupado=1 from the cycle after acceptance. Radix-2 shift-add for MUL and restoring division for DIVU/REMU, one bit per cycle, exactly LARGURA cycles. On the final CALC edge, saida is written, ocupado drops to 0, and pronto=1 in that same cycle. Latency LARGURA.
- Back-to-back: inicio in the same cycle as pronto is accepted, because ocupado=0 then.
- inicio while ocupado=1 is ignored. Input changes during CALC have no effect.
- Divide by zero (B=0): quotient all-ones, remainder = A. Still takes LARGURA cycles.
- pronto never asserts without a preceding accepted inicio.
- saida and zero change only at a completion or at reset.
- Reset mid-CALC aborts the operation: no pronto; saida=0.
- All arithmetic is LARGURA-wide. Carries and overflow are discarded. No flags other than zero.

Test Plan:
- Reset, then ADD A=0x7FFFFFFF, B=1 -> one cycle later saida=0x80000000, pronto pulse of 1 cycle, zero=0. Then SUB 5-5 -> saida=0, zero=1.
- SLTU vs SLT with A=0xFFFFFFFF, B=1 -> SLTU gives 0, SLT gives 1. SLL A=1, B=0x23 (shamt 3) -> 8. SRL A=0x80000000, B=31 -> 1.
- MUL 0x10000 * 0x10003 -> ocupado high exactly 32 cycles, then saida=0x00030000 with pronto. inicio pulsed mid-operation with ADD is ignored, and saida is unchanged until completion.
- DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9; each takes 32 cycles.
- Back-to-back: new MUL issued in the pronto cycle of the previous DIVU -> accepted, second pronto exactly 32 cycles later. Unknown opcode 1111 -> saida=0, zero=1, pronto after 1 cycle.
- Reset asserted at cycle 10 of a MUL -> the next cycle shows ocupado=0, saida=0, and no pronto ever. Repeat all directed cases with LARGURA=8, e.g. MUL 15*17 -> 0xFF in 8 cycles.
